// File: rtl/booth_pkg.sv
// Shared constants and types for the sequential radix-2 Booth multiplier.
// Includes the Booth recoding of the {Q[0], Q-1} pair.
package booth_pkg;

   localparam int WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_ADD  = 2'd1,
      OP_SUB  = 2'd2
   } booth_op_t;

   // 01 adds the multiplicand, 10 subtracts it, 00/11 leave A untouched.
   function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
      booth_op_t op;
      case ({q0, q_m1})
         2'b01:   op = OP_ADD;
         2'b10:   op = OP_SUB;
         default: op = OP_NONE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth step: conditional add/subtract of M into A,
// then arithmetic shift right of {A, Q, Q-1} by one bit.
module booth_step #(
   parameter int WIDTH = booth_pkg::WIDTH
) (
   input  logic [WIDTH:0]   acc,
   input  logic [WIDTH-1:0] q,
   input  logic             q_m1,
   input  logic [WIDTH:0]   m,
   output logic [WIDTH:0]   acc_next,
   output logic [WIDTH-1:0] q_next,
   output logic             q_m1_next
);
   import booth_pkg::*;

   logic [WIDTH:0] sum_s;

   // A and M carry one guard bit so that subtracting -2^(WIDTH-1) cannot overflow.
   always_comb begin
      sum_s = acc;
      case (booth_decode(q[0], q_m1))
         OP_ADD:  sum_s = acc + m;
         OP_SUB:  sum_s = acc - m;
         default: sum_s = acc;
      endcase
   end

   assign acc_next  = {sum_s[WIDTH], sum_s[WIDTH:1]};
   assign q_next    = {sum_s[0], q[WIDTH-1:1]};
   assign q_m1_next = q[0];

endmodule

// File: rtl/booth_algorithm.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, WIDTH steps per product.
// Launch on a rising edge of start; ready/result are registered and held until the next launch.
module booth_algorithm #(
   parameter int WIDTH = booth_pkg::WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 start,
   output logic                 ready,
   output logic [2*WIDTH-1:0]   result
);
   import booth_pkg::*;

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state_r;
   logic [CW-1:0]    cnt_r;
   logic             start_prev_r;
   logic [WIDTH:0]   m_r;
   logic [WIDTH:0]   acc_r;
   logic [WIDTH-1:0] q_r;
   logic             q_m1_r;

   logic [WIDTH:0]   acc_next_s;
   logic [WIDTH-1:0] q_next_s;
   logic             q_m1_next_s;
   logic             launch_s;
   logic             last_step_s;

   booth_step #(.WIDTH(WIDTH)) u_step (
      .acc       (acc_r),
      .q         (q_r),
      .q_m1      (q_m1_r),
      .m         (m_r),
      .acc_next  (acc_next_s),
      .q_next    (q_next_s),
      .q_m1_next (q_m1_next_s)
   );

   // Launch qualifier: a 0->1 start transition seen between consecutive edges.
   always_comb begin
      launch_s    = start & ~start_prev_r;
      last_step_s = (cnt_r == CW'(1));
   end

   // Controller FSM, datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         cnt_r        <= '0;
         start_prev_r <= 1'b0;
         m_r          <= '0;
         acc_r        <= '0;
         q_r          <= '0;
         q_m1_r       <= 1'b0;
         ready        <= 1'b0;
         result       <= '0;
      end else begin
         start_prev_r <= start;
         case (state_r)
            IDLE, DONE: begin
               if (launch_s) begin
                  m_r     <= {a[WIDTH-1], a};
                  acc_r   <= '0;
                  q_r     <= b;
                  q_m1_r  <= 1'b0;
                  cnt_r   <= CW'(WIDTH);
                  ready   <= 1'b0;
                  state_r <= RUN;
               end else begin
                  state_r <= state_r;
               end
            end
            RUN: begin
               acc_r  <= acc_next_s;
               q_r    <= q_next_s;
               q_m1_r <= q_m1_next_s;
               cnt_r  <= cnt_r - CW'(1);
               // The product fits in 2*WIDTH bits; A's guard bit is redundant here.
               if (last_step_s) begin
                  result  <= {acc_next_s[WIDTH-1:0], q_next_s};
                  ready   <= 1'b1;
                  state_r <= DONE;
               end else begin
                  state_r <= RUN;
               end
            end
            default: begin
               state_r <= IDLE;
               ready   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_algorithm.sv
// Self-checking bench for booth_algorithm: directed corners, mid-run reset,
// start-edge handling and a randomized run checked through an expected-result queue.
module tb_booth_algorithm;

   logic        clk;
   logic        rst;
   logic [15:0] a;
   logic [15:0] b;
   logic        start;
   logic        ready;
   logic [31:0] result;

   int          checks;
   int          failures;
   int          launches;
   int          done_cnt;
   logic        ready_seen;
   logic [31:0] last_result;
   logic [31:0] exp_q[$];

   booth_algorithm #(.WIDTH(16)) dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .b      (b),
      .start  (start),
      .ready  (ready),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y);
      longint p;
      p = longint'($signed(x)) * longint'($signed(y));
      return p[31:0];
   endfunction

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard: every rising edge of ready consumes one expected product.
   always @(negedge clk) begin
      if (ready === 1'b1 && ready_seen !== 1'b1) begin
         done_cnt++;
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_ready: observed=completion expected=no pending operation");
         end
         if (exp_q.size() != 0) check32("result", result, exp_q.pop_front());
      end
      ready_seen = ready;
   end

   // One launch with an exact expected product; checks latency and held result.
   task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] exp);
      int lat;
      a = av;
      b = bv;
      start = 1'b1;
      exp_q.push_back(exp);
      launches++;
      cyc(1);
      start = 1'b0;
      check32("ready_drop", 32'(ready), 32'd0);
      lat = 0;
      while (ready !== 1'b1 && lat < 40) begin
         cyc(1);
         lat++;
         if (lat == 8) check32("result_held", result, last_result);
      end
      check32("latency", 32'(lat), 32'd16);
      last_result = exp;
   endtask

   initial begin
      logic [15:0] av;
      logic [15:0] bv;
      checks = 0; failures = 0; launches = 0; done_cnt = 0;
      ready_seen = 1'b0; last_result = 32'd0;
      rst = 1'b1; start = 1'b0; a = 16'd0; b = 16'd0;
      cyc(3);
      check32("reset_ready", 32'(ready), 32'd0);
      check32("reset_result", result, 32'd0);
      rst = 1'b0;
      cyc(1);

      run_op(16'd4,     16'd7,     32'd28);
      run_op(16'd1,     16'd7,     32'd7);
      run_op(16'd1,     16'hFFFF,  32'hFFFF_FFFF);
      run_op(16'hFFF6,  16'hFFFF,  32'd10);
      run_op(16'h8000,  16'h8000,  32'h4000_0000);
      run_op(16'h8000,  16'h7FFF,  32'hC000_8000);
      run_op(16'd0,     16'h1234,  32'd0);
      run_op(16'h9ABC,  16'd0,     32'd0);
      run_op(16'h5555,  16'hAAAA,  32'hE38E_1C72);

      // Operands change mid-run, start held, and a start edge arrives during RUN.
      a = 16'd3; b = 16'd5; start = 1'b1;
      exp_q.push_back(32'd15);
      launches++;
      cyc(1);
      for (int k = 1; k <= 8; k++) begin
         cyc(1);
         if (k == 4) begin
            a = 16'h7FFF;
            b = 16'h8000;
         end
      end
      start = 1'b0;
      check32("hold_during_run", result, last_result);
      cyc(3);
      start = 1'b1;
      cyc(13);
      check32("no_relaunch_ready", 32'(ready), 32'd1);
      check32("no_relaunch_result", result, 32'd15);
      check32("no_relaunch_count", 32'(done_cnt), 32'(launches));
      start = 1'b0;
      cyc(2);
      last_result = 32'd15;

      // Reset in the middle of a run aborts it.
      a = 16'd9; b = 16'd9; start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(7);
      rst = 1'b1;
      cyc(1);
      check32("midrun_reset_ready", 32'(ready), 32'd0);
      check32("midrun_reset_result", result, 32'd0);
      rst = 1'b0;
      last_result = 32'd0;
      run_op(16'd6, 16'hFFF9, 32'hFFFF_FFD6);

      // Random pairs, start toggled every 9 cycles.
      for (int i = 0; i < 1000; i++) begin
         av = 16'($urandom);
         bv = 16'($urandom);
         if (i % 97 == 0) av = 16'h8000;
         if (i % 89 == 0) bv = 16'h8000;
         a = av;
         b = bv;
         start = 1'b1;
         exp_q.push_back(ref_prod(av, bv));
         launches++;
         cyc(9);
         start = 1'b0;
         cyc(9);
      end
      cyc(4);
      check32("queue_empty", 32'(exp_q.size()), 32'd0);
      check32("completions", 32'(done_cnt), 32'(launches));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
